fft_bfly2_pipe: RTL and testbench
=================================

// Module: fft_bfly2_pipe
// PURPOSE
//  Pipelined, parametrised radix-2 DIT butterfly: o1 = a + b*W, o2 = a - b*W.
//  Successor to the combinational butterfly. Adds valid/ready flow control,
//  3-stage pipeline, forward/inverse mode, per-sample 1/2 scaling and round-half-up.
//  One instance per stage in the 64-point FFT datapath, fed by the stage memory and twiddle ROM.
// PARAMETERS
//  DATA_INP_WD  16  signed width of a/b re/im inputs
//  DATA_OUT_WD  16  signed width of o1/o2 re/im outputs
//  DATA_W_N_WD  16  signed width of twiddle re/im
//  DATA_FRC_WD  14  twiddle fraction bits (16384 = 1.0)
// PORTS
//  clk             in   1            clock, all logic rising-edge
//  rst             in   1            synchronous, active-high reset
//  vld_i           in   1            input sample valid
//  rdy_o           out  1            block accepts input this cycle
//  inv_i           in   1            1: use conj(W) (IFFT); sampled with vld_i
//  scl_i           in   1            1: extra >>>1 on outputs; sampled with vld_i
//  dat_fft_1_re_i  in   DATA_INP_WD  a real
//  dat_fft_1_im_i  in   DATA_INP_WD  a imag
//  dat_fft_2_re_i  in   DATA_INP_WD  b real
//  dat_fft_2_im_i  in   DATA_INP_WD  b imag
//  dat_wn_re_i     in   DATA_W_N_WD  twiddle real
//  dat_wn_im_i     in   DATA_W_N_WD  twiddle imag
//  vld_o           out  1            output sample valid
//  rdy_i           in   1            downstream accepts output
//  dat_fft_1_re_o  out  DATA_OUT_WD  o1 real    (dat_fft_1_im_o: o1 imag)
//  dat_fft_2_re_o  out  DATA_OUT_WD  o2 real    (dat_fft_2_im_o: o2 imag)
//  ovf_o           out  1            any of the 4 results out of range; qualified by vld_o
// BEHAVIOUR
//  - Reset: all stage valids, vld_o, ovf_o, data outputs = 0. rdy_o = 1 in the cycle after reset.
//  - Pipeline stages:
//      S1 registers inputs and modes.
//      S2 registers 4 products; inv: wn_im negated.
//      S3 does add/sub, round, shift, clip and registers the outputs.
//  - Latency 3 cycles from accepted vld_i to vld_o with no stall. Throughput 1 sample per cycle.
//  - Global stall: en = ~vld_o | rdy_i; rdy_o = en.
//      Stalled: all stages hold, outputs stable. Accept on vld_i & rdy_o.
//  - Bubbles propagate as valid=0. Data registers may load junk under valid=0.
//  - Arithmetic, ACC_WD = DATA_INP_WD+DATA_W_N_WD+2:
//      p = b*W, full precision.
//      s = (a <<< FRC) +/- p.
//      sh = FRC + scl.
//      r = (s + (1 <<< (sh-1))) >>> sh   (round half up toward +inf).
//  - inv/scl are per-sample and travel with data. A mode change between back-to-back samples is legal.
//  - Reset asserted mid-operation: all in-flight samples dropped; vld_o = 0 next cycle.
//  - ovf_o is computed from r vs [-2^(OUT-1), 2^(OUT-1)-1]. It is 0 whenever vld_o = 0.
// CONFIGURATION
//  FFT_BFLY_SAT_EN defined:     out-of-range r clipped to max/min positive/negative code.
//  FFT_BFLY_SAT_EN not defined: r truncated to low DATA_OUT_WD bits (two's complement wrap).
//  ovf_o behaves identically in both builds.
// STRUCTURE
//  - fft_defines.vh holds the shared constants:
//      default widths, FRC, ACC_WD formula, rounding constant macro.
//  - One sub-module: fft_cmul_pipe.
//      Registered complex multiply with conj option.
//      Reused later by the radix-4 stage.
//  - Add/sub, round and clip stay in the top module.
// TESTING (defaults, W=(16384,0) is 1.0, inv=scl=0 unless stated)
//  1 a=(100,0) b=(50,0) W=(16384,0) -> o1=(150,0) o2=(50,0), vld_o exactly 3 cycles after vld_i
//  2 a=(0,0) b=(0,100) W=(0,16384):
//      inv=0 -> o1=(-100,0) o2=(100,0)
//      inv=1 -> o1=(100,0) o2=(-100,0)
//  3 a=(101,0) b=(0,0) scl=1 -> o1=(51,0) o2=(51,0) (round half up); a=(-101,0) -> (-50,0)
//  4 a=(32767,0) b=(32767,0):
//      SAT_EN   -> o1.re=32767, ovf_o=1
//      no SAT   -> o1.re=-2, ovf_o=1
//      o2=(0,0) in both builds
//  5 stream 8 samples, rdy_i low 2 cycles mid-stream -> rdy_o low, outputs held, all 8 out in order, no dup/loss
//  6 rst for 1 cycle with 2 samples in flight -> vld_o=0 next cycle, no stale sample emitted afterward

Source files
------------

// File: rtl/fft_bfly2_pipe_pkg.sv
// Shared constants and types for the radix-2 butterfly datapath.
// Default widths, twiddle fraction bits and the accumulator width rule live here.
package fft_bfly2_pipe_pkg;

    localparam int DEF_INP_WD = 16;
    localparam int DEF_OUT_WD = 16;
    localparam int DEF_WN_WD  = 16;
    localparam int DEF_FRC_WD = 14;

    // Per-sample mode bits that travel down the pipe alongside the data.
    typedef struct packed {
        logic inv;
        logic scl;
    } mode_t;

    // Wide enough for (a <<< FRC) +/- (b*W) plus the rounding increment.
    function automatic int acc_wd(input int inp_wd, input int wn_wd);
        return inp_wd + wn_wd + 2;
    endfunction

endpackage

// File: rtl/fft_cmul_pipe.sv
// Registered complex-multiply partial products b*W, optionally with conj(W).
// Latency: 1 cycle. Backpressure: holds its registers whenever en_i is low.
// Shared with the radix-4 stage, so only the four products are formed here.
module fft_cmul_pipe
    import fft_bfly2_pipe_pkg::*;
#(
    parameter int B_WD = DEF_INP_WD,
    parameter int W_WD = DEF_WN_WD,
    parameter int P_WD = B_WD + W_WD + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   conj_i,
    input  logic signed [B_WD-1:0] b_re_i,
    input  logic signed [B_WD-1:0] b_im_i,
    input  logic signed [W_WD-1:0] w_re_i,
    input  logic signed [W_WD-1:0] w_im_i,
    output logic signed [P_WD-1:0] p_rr_o,
    output logic signed [P_WD-1:0] p_ii_o,
    output logic signed [P_WD-1:0] p_ri_o,
    output logic signed [P_WD-1:0] p_ir_o
);

    // One extra bit so negating the most negative twiddle cannot wrap.
    logic signed [W_WD:0]   w_im_ext;
    logic signed [W_WD:0]   w_im_eff;
    logic signed [P_WD-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [P_WD-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    assign w_im_ext = {w_im_i[W_WD-1], w_im_i};
    assign w_im_eff = conj_i ? -w_im_ext : w_im_ext;

    assign p_rr_d = P_WD'(b_re_i) * P_WD'(w_re_i);
    assign p_ii_d = P_WD'(b_im_i) * P_WD'(w_im_eff);
    assign p_ri_d = P_WD'(b_re_i) * P_WD'(w_im_eff);
    assign p_ir_d = P_WD'(b_im_i) * P_WD'(w_re_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (en_i) begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
        end
    end

    assign p_rr_o = p_rr_q;
    assign p_ii_o = p_ii_q;
    assign p_ri_o = p_ri_q;
    assign p_ir_o = p_ir_q;

endmodule

// File: rtl/fft_bfly2_pipe.sv
// Radix-2 DIT butterfly o1 = a + b*W, o2 = a - b*W with per-sample conj/scale; FFT_BFLY_SAT_EN selects clip vs wrap.
// Latency: 3 cycles, 1 sample/cycle. Backpressure: global stall, rdy_o = ~vld_o | rdy_i.
// All three stages freeze together while the output is valid and not taken.
module fft_bfly2_pipe
    import fft_bfly2_pipe_pkg::*;
#(
    parameter int DATA_INP_WD = DEF_INP_WD,
    parameter int DATA_OUT_WD = DEF_OUT_WD,
    parameter int DATA_W_N_WD = DEF_WN_WD,
    parameter int DATA_FRC_WD = DEF_FRC_WD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_i,
    output logic                          rdy_o,
    input  logic                          inv_i,
    input  logic                          scl_i,
    input  logic signed [DATA_INP_WD-1:0] dat_fft_1_re_i,
    input  logic signed [DATA_INP_WD-1:0] dat_fft_1_im_i,
    input  logic signed [DATA_INP_WD-1:0] dat_fft_2_re_i,
    input  logic signed [DATA_INP_WD-1:0] dat_fft_2_im_i,
    input  logic signed [DATA_W_N_WD-1:0] dat_wn_re_i,
    input  logic signed [DATA_W_N_WD-1:0] dat_wn_im_i,
    output logic                          vld_o,
    input  logic                          rdy_i,
    output logic signed [DATA_OUT_WD-1:0] dat_fft_1_re_o,
    output logic signed [DATA_OUT_WD-1:0] dat_fft_1_im_o,
    output logic signed [DATA_OUT_WD-1:0] dat_fft_2_re_o,
    output logic signed [DATA_OUT_WD-1:0] dat_fft_2_im_o,
    output logic                          ovf_o
);

    localparam int P_WD   = DATA_INP_WD + DATA_W_N_WD + 1;
    localparam int ACC_WD = acc_wd(DATA_INP_WD, DATA_W_N_WD);

    localparam logic signed [ACC_WD-1:0] ONE      = 1;
    localparam logic signed [ACC_WD-1:0] RND_HALF = ONE <<< (DATA_FRC_WD - 1);
    localparam logic signed [ACC_WD-1:0] RND_FULL = ONE <<< DATA_FRC_WD;
    localparam logic signed [ACC_WD-1:0] OUT_MAX  = (ONE <<< (DATA_OUT_WD - 1)) - ONE;
    localparam logic signed [ACC_WD-1:0] OUT_MIN  = -(ONE <<< (DATA_OUT_WD - 1));

    logic en;

    logic                          s1_vld_q;
    mode_t                         s1_mode_q;
    logic signed [DATA_INP_WD-1:0] s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q;
    logic signed [DATA_W_N_WD-1:0] s1_w_re_q, s1_w_im_q;

    logic                          s2_vld_q;
    logic                          s2_scl_q;
    logic signed [DATA_INP_WD-1:0] s2_a_re_q, s2_a_im_q;
    logic signed [P_WD-1:0]        p_rr, p_ii, p_ri, p_ir;

    logic signed [ACC_WD-1:0]      p_re, p_im, a_re_sh, a_im_sh;
    logic signed [ACC_WD-1:0]      r1_re, r1_im, r2_re, r2_im;

    logic                          vld_q, ovf_q, ovf_d;
    logic signed [DATA_OUT_WD-1:0] o1_re_q, o1_im_q, o2_re_q, o2_im_q;
    logic signed [DATA_OUT_WD-1:0] o1_re_d, o1_im_d, o2_re_d, o2_im_d;

    assign en    = ~vld_q | rdy_i;
    assign rdy_o = en;

    // Round half up: add half an LSB of the final scale, then arithmetic shift.
    function automatic logic signed [ACC_WD-1:0] rnd_shift(input logic signed [ACC_WD-1:0] s,
                                                           input logic                     scl);
        logic signed [ACC_WD-1:0] t;
        if (scl) begin
            t = s + RND_FULL;
            return t >>> (DATA_FRC_WD + 1);
        end else begin
            t = s + RND_HALF;
            return t >>> DATA_FRC_WD;
        end
    endfunction

    function automatic logic is_ovf(input logic signed [ACC_WD-1:0] r);
        return (r > OUT_MAX) || (r < OUT_MIN);
    endfunction

    function automatic logic signed [DATA_OUT_WD-1:0] fit(input logic signed [ACC_WD-1:0] r);
`ifdef FFT_BFLY_SAT_EN
        if (r > OUT_MAX) begin
            return OUT_MAX[DATA_OUT_WD-1:0];
        end else if (r < OUT_MIN) begin
            return OUT_MIN[DATA_OUT_WD-1:0];
        end else begin
            return r[DATA_OUT_WD-1:0];
        end
`else
        return r[DATA_OUT_WD-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_mode_q <= '0;
            s1_a_re_q <= '0;
            s1_a_im_q <= '0;
            s1_b_re_q <= '0;
            s1_b_im_q <= '0;
            s1_w_re_q <= '0;
            s1_w_im_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_scl_q  <= 1'b0;
            s2_a_re_q <= '0;
            s2_a_im_q <= '0;
        end else if (en) begin
            s1_vld_q      <= vld_i;
            s1_mode_q.inv <= inv_i;
            s1_mode_q.scl <= scl_i;
            s1_a_re_q     <= dat_fft_1_re_i;
            s1_a_im_q     <= dat_fft_1_im_i;
            s1_b_re_q     <= dat_fft_2_re_i;
            s1_b_im_q     <= dat_fft_2_im_i;
            s1_w_re_q     <= dat_wn_re_i;
            s1_w_im_q     <= dat_wn_im_i;
            s2_vld_q      <= s1_vld_q;
            s2_scl_q      <= s1_mode_q.scl;
            s2_a_re_q     <= s1_a_re_q;
            s2_a_im_q     <= s1_a_im_q;
        end
    end

    fft_cmul_pipe #(
        .B_WD (DATA_INP_WD),
        .W_WD (DATA_W_N_WD),
        .P_WD (P_WD)
    ) u_cmul (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .conj_i (s1_mode_q.inv),
        .b_re_i (s1_b_re_q),
        .b_im_i (s1_b_im_q),
        .w_re_i (s1_w_re_q),
        .w_im_i (s1_w_im_q),
        .p_rr_o (p_rr),
        .p_ii_o (p_ii),
        .p_ri_o (p_ri),
        .p_ir_o (p_ir)
    );

    assign p_re    = ACC_WD'(p_rr) - ACC_WD'(p_ii);
    assign p_im    = ACC_WD'(p_ri) + ACC_WD'(p_ir);
    assign a_re_sh = ACC_WD'(s2_a_re_q) <<< DATA_FRC_WD;
    assign a_im_sh = ACC_WD'(s2_a_im_q) <<< DATA_FRC_WD;

    assign r1_re = rnd_shift(a_re_sh + p_re, s2_scl_q);
    assign r1_im = rnd_shift(a_im_sh + p_im, s2_scl_q);
    assign r2_re = rnd_shift(a_re_sh - p_re, s2_scl_q);
    assign r2_im = rnd_shift(a_im_sh - p_im, s2_scl_q);

    assign o1_re_d = fit(r1_re);
    assign o1_im_d = fit(r1_im);
    assign o2_re_d = fit(r2_re);
    assign o2_im_d = fit(r2_im);
    // Gated by the stage valid so ovf_o never flags a bubble.
    assign ovf_d   = s2_vld_q & (is_ovf(r1_re) | is_ovf(r1_im) | is_ovf(r2_re) | is_ovf(r2_im));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            o1_re_q <= '0;
            o1_im_q <= '0;
            o2_re_q <= '0;
            o2_im_q <= '0;
        end else if (en) begin
            vld_q   <= s2_vld_q;
            ovf_q   <= ovf_d;
            o1_re_q <= o1_re_d;
            o1_im_q <= o1_im_d;
            o2_re_q <= o2_re_d;
            o2_im_q <= o2_im_d;
        end
    end

    assign vld_o          = vld_q;
    assign ovf_o          = ovf_q;
    assign dat_fft_1_re_o = o1_re_q;
    assign dat_fft_1_im_o = o1_im_q;
    assign dat_fft_2_re_o = o2_re_q;
    assign dat_fft_2_im_o = o2_im_q;

endmodule

// File: tb/tb_fft_bfly2_pipe.sv
// Directed-vector bench for fft_bfly2_pipe; expectations are hand-computed butterfly results.
module tb_fft_bfly2_pipe;

    logic clk = 1'b0;
    logic rst;
    logic vld_i, rdy_o, inv_i, scl_i, vld_o, rdy_i, ovf_o;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [15:0] o1_re, o1_im, o2_re, o2_im;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_bfly2_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .vld_i          (vld_i),
        .rdy_o          (rdy_o),
        .inv_i          (inv_i),
        .scl_i          (scl_i),
        .dat_fft_1_re_i (a_re),
        .dat_fft_1_im_i (a_im),
        .dat_fft_2_re_i (b_re),
        .dat_fft_2_im_i (b_im),
        .dat_wn_re_i    (w_re),
        .dat_wn_im_i    (w_im),
        .vld_o          (vld_o),
        .rdy_i          (rdy_i),
        .dat_fft_1_re_o (o1_re),
        .dat_fft_1_im_o (o1_im),
        .dat_fft_2_re_o (o2_re),
        .dat_fft_2_im_o (o2_im),
        .ovf_o          (ovf_o)
    );

    task automatic drive(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input logic inv, input logic scl);
        vld_i = 1'b1;
        a_re  = 16'(ar);
        a_im  = 16'(ai);
        b_re  = 16'(br);
        b_im  = 16'(bi);
        w_re  = 16'(wr);
        w_im  = 16'(wi);
        inv_i = inv;
        scl_i = scl;
    endtask

    // Sends one sample with rdy_i high and waits (bounded) for its result.
    task automatic run_one(input int ar, input int ai, input int br, input int bi,
                           input int wr, input int wi, input logic inv, input logic scl,
                           output int lat, output logic [63:0] outs, output logic ovf);
        @(negedge clk);
        drive(ar, ai, br, bi, wr, wi, inv, scl);
        @(negedge clk);
        vld_i = 1'b0;
        lat   = 1;
        while (vld_o !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        outs = {o1_re, o1_im, o2_re, o2_im};
        ovf  = ovf_o;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rdy_i = 1'b1;
        vld_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        vld_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vld_o, ovf_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_vld_ovf got=%b exp=00", {vld_o, ovf_o});
        end
        checks++;
        if ({o1_re, o1_im, o2_re, o2_im} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {o1_re, o1_im, o2_re, o2_im});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=1", rdy_o);
        end
    endtask

    task automatic test_basic();
        int lat; logic [63:0] outs; logic ovf;
        run_one(100, 0, 50, 0, 16384, 0, 1'b0, 1'b0, lat, outs, ovf);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=3", lat);
        end
        checks++;
        if (outs !== {16'sd150, 16'sd0, 16'sd50, 16'sd0} || ovf !== 1'b0) begin
            failures++;
            $display("FAIL basic_data got=%h ovf=%b exp=%h ovf=0", outs, ovf,
                     {16'sd150, 16'sd0, 16'sd50, 16'sd0});
        end
    endtask

    task automatic test_twiddle_inv();
        int lat; logic [63:0] outs; logic ovf;
        run_one(0, 0, 0, 100, 0, 16384, 1'b0, 1'b0, lat, outs, ovf);
        checks++;
        if (outs !== {-16'sd100, 16'sd0, 16'sd100, 16'sd0} || lat !== 3) begin
            failures++;
            $display("FAIL twiddle_fwd got=%h lat=%0d exp=%h lat=3", outs, lat,
                     {-16'sd100, 16'sd0, 16'sd100, 16'sd0});
        end
        run_one(0, 0, 0, 100, 0, 16384, 1'b1, 1'b0, lat, outs, ovf);
        checks++;
        if (outs !== {16'sd100, 16'sd0, -16'sd100, 16'sd0} || lat !== 3) begin
            failures++;
            $display("FAIL twiddle_inv got=%h lat=%0d exp=%h lat=3", outs, lat,
                     {16'sd100, 16'sd0, -16'sd100, 16'sd0});
        end
    endtask

    task automatic test_round_scale();
        int lat; logic [63:0] outs; logic ovf;
        run_one(101, 0, 0, 0, 16384, 0, 1'b0, 1'b1, lat, outs, ovf);
        checks++;
        if (outs !== {16'sd51, 16'sd0, 16'sd51, 16'sd0}) begin
            failures++;
            $display("FAIL round_pos got=%h exp=%h", outs, {16'sd51, 16'sd0, 16'sd51, 16'sd0});
        end
        run_one(-101, 0, 0, 0, 16384, 0, 1'b0, 1'b1, lat, outs, ovf);
        checks++;
        if (outs !== {-16'sd50, 16'sd0, -16'sd50, 16'sd0}) begin
            failures++;
            $display("FAIL round_neg got=%h exp=%h", outs, {-16'sd50, 16'sd0, -16'sd50, 16'sd0});
        end
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] outs; logic ovf;
        logic signed [15:0] exp_re;
`ifdef FFT_BFLY_SAT_EN
        exp_re = 16'sd32767;
`else
        exp_re = -16'sd2;
`endif
        run_one(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, lat, outs, ovf);
        checks++;
        if (outs !== {exp_re, 16'sd0, 16'sd0, 16'sd0}) begin
            failures++;
            $display("FAIL ovf_data got=%h exp=%h", outs, {exp_re, 16'sd0, 16'sd0, 16'sd0});
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got=%b exp=1", ovf);
        end
        @(negedge clk);
        checks++;
        if ({vld_o, ovf_o} !== 2'b00) begin
            failures++;
            $display("FAIL ovf_bubble got=%b exp=00", {vld_o, ovf_o});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 0, 0, 100, 0, 16384, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 100, 0, 16384, 1'b1, 1'b0);
        @(negedge clk);
        vld_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({vld_o, o1_re, o1_im, o2_re, o2_im} !== {1'b1, -16'sd100, 16'sd0, 16'sd100, 16'sd0}) begin
            failures++;
            $display("FAIL b2b_first got=%b %h", vld_o, {o1_re, o1_im, o2_re, o2_im});
        end
        @(negedge clk);
        checks++;
        if ({vld_o, o1_re, o1_im, o2_re, o2_im} !== {1'b1, 16'sd100, 16'sd0, -16'sd100, 16'sd0}) begin
            failures++;
            $display("FAIL b2b_second got=%b %h", vld_o, {o1_re, o1_im, o2_re, o2_im});
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int sent = 0;
        int recvd = 0;
        logic stalled_prev = 1'b0;
        logic [63:0] held = '0;
        logic signed [15:0] e1r, e1i, e2r, e2i;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (stalled_prev) begin
                checks++;
                if ({vld_o, o1_re, o1_im, o2_re, o2_im} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b %h exp=1 %h", cyc, vld_o,
                             {o1_re, o1_im, o2_re, o2_im}, held);
                end
            end
            rdy_i = !(cyc == 5 || cyc == 6);
            if (sent < 8)
                drive(100 * sent + 7, -3 * sent, 10 * sent, 5, 16384, 0, 1'b0, 1'b0);
            else
                vld_i = 1'b0;
            #1;
            if (!rdy_i && vld_o === 1'b1) begin
                checks++;
                if (rdy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_rdy cyc=%0d got=%b exp=0", cyc, rdy_o);
                end
            end
            if (vld_o === 1'b1 && rdy_i) begin
                e1r = 16'(110 * recvd + 7);
                e1i = 16'(-3 * recvd + 5);
                e2r = 16'(90 * recvd + 7);
                e2i = 16'(-3 * recvd - 5);
                checks++;
                if (recvd >= 8 || {o1_re, o1_im, o2_re, o2_im} !== {e1r, e1i, e2r, e2i}) begin
                    failures++;
                    $display("FAIL stream_out idx=%0d got=%h exp=%h", recvd,
                             {o1_re, o1_im, o2_re, o2_im}, {e1r, e1i, e2r, e2i});
                end
                recvd++;
            end
            stalled_prev = (vld_o === 1'b1) && !rdy_i;
            held = {o1_re, o1_im, o2_re, o2_im};
            if (vld_i && rdy_o === 1'b1) sent++;
        end
        vld_i = 1'b0;
        rdy_i = 1'b1;
        checks++;
        if (recvd !== 8 || sent !== 8) begin
            failures++;
            $display("FAIL stream_count got=%0d sent=%0d exp=8", recvd, sent);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        int lat; logic [63:0] outs; logic ovf;
        @(negedge clk);
        drive(1000, 0, 0, 0, 16384, 0, 1'b0, 1'b0);
        @(negedge clk);
        drive(2000, 0, 0, 0, 16384, 0, 1'b0, 1'b0);
        @(negedge clk);
        vld_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (vld_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_vld got=%b exp=0", vld_o);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vld_o !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_mid_stale got=%0d exp=0", seen);
        end
        run_one(-300, 40, 20, -10, 16384, 0, 1'b0, 1'b0, lat, outs, ovf);
        checks++;
        if (lat !== 3 || outs !== {-16'sd280, 16'sd30, -16'sd320, 16'sd50}) begin
            failures++;
            $display("FAIL rst_recover got=%h lat=%0d exp=%h lat=3", outs, lat,
                     {-16'sd280, 16'sd30, -16'sd320, 16'sd50});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_twiddle_inv();
        test_round_scale();
        test_overflow();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
